// File: rtl/tahmin_kontrol.sv
// Round sequencer for the number-guessing grid: button edges -> step registers, attempt counting, win/loss.
// Optional SECIM idle timeout is compiled in with `define TAHMIN_ZAMAN_ASIMI_EN.
module tahmin_kontrol #(
    parameter int unsigned MAX_DENEME   = 3,
    parameter int unsigned ZAMAN_SINIRI = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baslat,
    input  logic       btn_sag,
    input  logic       btn_asagi,
    input  logic       btn_onay,
    input  logic [3:0] sayi_giris,
    input  logic       tahmin_dogru,
    output logic [1:0] sag_adim,
    output logic [1:0] asagi_adim,
    output logic [3:0] sayi,
    output logic [3:0] kalan_deneme,
    output logic [2:0] durum,
    output logic       kontrol_gecerli,
    output logic       kazandi,
    output logic       kaybetti,
    output logic       zaman_asimi
);

    typedef enum logic [2:0] {
        BOSTA    = 3'd0,
        SECIM    = 3'd1,
        KONTROL  = 3'd2,
        KAZANDI  = 3'd3,
        KAYBETTI = 3'd4
    } durum_t;

    durum_t     r_durum;
    logic [1:0] r_sag_adim;
    logic [1:0] r_asagi_adim;
    logic [3:0] r_sayi;
    logic [3:0] r_kalan;
    logic       r_baslat_q;
    logic       r_sag_q;
    logic       r_asagi_q;
    logic       r_onay_q;

    logic w_baslat_bas;
    logic w_sag_bas;
    logic w_asagi_bas;
    logic w_onay_bas;

    // Previous-sample copies reset high so a button held through reset must be released first.
    assign w_baslat_bas = baslat    & ~r_baslat_q;
    assign w_sag_bas    = btn_sag   & ~r_sag_q;
    assign w_asagi_bas  = btn_asagi & ~r_asagi_q;
    assign w_onay_bas   = btn_onay  & ~r_onay_q;

`ifdef TAHMIN_ZAMAN_ASIMI_EN
    localparam logic [15:0] SAYAC_SON = 16'(ZAMAN_SINIRI - 1);
    logic [15:0] r_sayac;
    logic        r_zaman_asimi;
    assign zaman_asimi = r_zaman_asimi;
`else
    // Feature compiled out: constant low, parameter kept for interface compatibility.
    assign zaman_asimi = 1'b0 & (|ZAMAN_SINIRI);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_durum      <= BOSTA;
            r_sag_adim   <= '0;
            r_asagi_adim <= '0;
            r_sayi       <= '0;
            r_kalan      <= '0;
            r_baslat_q   <= 1'b1;
            r_sag_q      <= 1'b1;
            r_asagi_q    <= 1'b1;
            r_onay_q     <= 1'b1;
`ifdef TAHMIN_ZAMAN_ASIMI_EN
            r_sayac       <= '0;
            r_zaman_asimi <= 1'b0;
`endif
        end else begin
            r_baslat_q <= baslat;
            r_sag_q    <= btn_sag;
            r_asagi_q  <= btn_asagi;
            r_onay_q   <= btn_onay;
`ifdef TAHMIN_ZAMAN_ASIMI_EN
            r_zaman_asimi <= 1'b0;
`endif
            case (r_durum)
                BOSTA, KAZANDI, KAYBETTI: begin
                    if (w_baslat_bas) begin
                        r_durum      <= SECIM;
                        r_sayi       <= sayi_giris;
                        r_sag_adim   <= '0;
                        r_asagi_adim <= '0;
                        r_kalan      <= 4'(MAX_DENEME);
`ifdef TAHMIN_ZAMAN_ASIMI_EN
                        r_sayac      <= '0;
`endif
                    end
                end
                SECIM: begin
                    if (w_onay_bas) begin
                        r_durum <= KONTROL;
                    end else begin
                        if (w_sag_bas)
                            r_sag_adim <= r_sag_adim + 2'd1;
                        if (w_asagi_bas)
                            r_asagi_adim <= r_asagi_adim + 2'd1;
`ifdef TAHMIN_ZAMAN_ASIMI_EN
                        // A move press restarts the idle window even on the would-be timeout cycle.
                        if (w_sag_bas || w_asagi_bas) begin
                            r_sayac <= '0;
                        end else if (r_sayac == SAYAC_SON) begin
                            r_durum       <= KONTROL;
                            r_zaman_asimi <= 1'b1;
                        end else begin
                            r_sayac <= r_sayac + 16'd1;
                        end
`endif
                    end
                end
                KONTROL: begin
                    if (tahmin_dogru) begin
                        r_durum <= KAZANDI;
                    end else if (r_kalan == 4'd1) begin
                        r_durum <= KAYBETTI;
                        r_kalan <= '0;
                    end else begin
                        r_durum <= SECIM;
                        r_kalan <= r_kalan - 4'd1;
`ifdef TAHMIN_ZAMAN_ASIMI_EN
                        r_sayac <= '0;
`endif
                    end
                end
                default: r_durum <= BOSTA;
            endcase
        end
    end

    assign sag_adim        = r_sag_adim;
    assign asagi_adim      = r_asagi_adim;
    assign sayi            = r_sayi;
    assign kalan_deneme    = r_kalan;
    assign durum           = r_durum;
    assign kontrol_gecerli = (r_durum == KONTROL);
    assign kazandi         = (r_durum == KAZANDI);
    assign kaybetti        = (r_durum == KAYBETTI);

endmodule

// File: tb/tb_tahmin_kontrol.sv
// Directed bench for tahmin_kontrol: expected output vectors are queued with each stimulus step and checked after the edge.
module tb_tahmin_kontrol;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baslat = 1'b0;
    logic       btn_sag = 1'b1;
    logic       btn_asagi = 1'b0;
    logic       btn_onay = 1'b0;
    logic [3:0] sayi_giris = 4'h0;
    logic       tahmin_dogru = 1'b0;
    logic [1:0] sag_adim;
    logic [1:0] asagi_adim;
    logic [3:0] sayi;
    logic [3:0] kalan_deneme;
    logic [2:0] durum;
    logic       kontrol_gecerli;
    logic       kazandi;
    logic       kaybetti;
    logic       zaman_asimi;

    always #5 clk = ~clk;

    tahmin_kontrol #(.MAX_DENEME(3), .ZAMAN_SINIRI(10)) dut (
        .clk            (clk),
        .rst            (rst),
        .baslat         (baslat),
        .btn_sag        (btn_sag),
        .btn_asagi      (btn_asagi),
        .btn_onay       (btn_onay),
        .sayi_giris     (sayi_giris),
        .tahmin_dogru   (tahmin_dogru),
        .sag_adim       (sag_adim),
        .asagi_adim     (asagi_adim),
        .sayi           (sayi),
        .kalan_deneme   (kalan_deneme),
        .durum          (durum),
        .kontrol_gecerli(kontrol_gecerli),
        .kazandi        (kazandi),
        .kaybetti       (kaybetti),
        .zaman_asimi    (zaman_asimi)
    );

    logic [18:0] q_exp[$];
    string       q_tag[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    // Vector layout: {durum, sag, asagi, sayi, kalan, kontrol_gecerli, kazandi, kaybetti, zaman_asimi}
    function automatic logic [18:0] e(input logic [2:0] d, input logic [1:0] s, input logic [1:0] a,
                                      input logic [3:0] sy, input logic [3:0] k, input logic kg,
                                      input logic kz, input logic ky, input logic za);
        return {d, s, a, sy, k, kg, kz, ky, za};
    endfunction

    task automatic check();
        logic [18:0] got;
        logic [18:0] want;
        string       t;
        got  = {durum, sag_adim, asagi_adim, sayi, kalan_deneme, kontrol_gecerli, kazandi, kaybetti, zaman_asimi};
        want = q_exp.pop_front();
        t    = q_tag.pop_front();
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", t, got, want);
        end
    endtask

    // b = {baslat, btn_sag, btn_asagi, btn_onay}
    task automatic step(input logic r, input logic [3:0] b, input logic td, input logic [3:0] sg,
                        input logic [18:0] x, input string tag);
        rst          = r;
        {baslat, btn_sag, btn_asagi, btn_onay} = b;
        tahmin_dogru = td;
        sayi_giris   = sg;
        q_exp.push_back(x);
        q_tag.push_back(tag);
        @(posedge clk);
        #1;
        check();
    endtask

    initial begin
        // Reset with sag held, start a round, then a real press
        step(1, 4'b0100, 0, 4'h0, e(0,0,0,4'h0,4'd0,0,0,0,0), "reset_values");
        step(0, 4'b0100, 0, 4'h0, e(0,0,0,4'h0,4'd0,0,0,0,0), "held_sag_bosta");
        step(0, 4'b1100, 0, 4'h0, e(1,0,0,4'h0,4'd3,0,0,0,0), "start_with_sag_held");
        step(0, 4'b0100, 0, 4'h0, e(1,0,0,4'h0,4'd3,0,0,0,0), "sag_held_no_press");
        step(0, 4'b0000, 0, 4'h0, e(1,0,0,4'h0,4'd3,0,0,0,0), "sag_release");
        step(0, 4'b0100, 0, 4'h0, e(1,1,0,4'h0,4'd3,0,0,0,0), "sag_first_press");
        step(0, 4'b0100, 0, 4'h0, e(1,1,0,4'h0,4'd3,0,0,0,0), "sag_no_repeat");
        step(0, 4'b0000, 0, 4'h0, e(1,1,0,4'h0,4'd3,0,0,0,0), "sag_release2");
        step(0, 4'b1000, 0, 4'hA, e(1,1,0,4'h0,4'd3,0,0,0,0), "baslat_ignored_secim");
        step(0, 4'b0000, 0, 4'hA, e(1,1,0,4'h0,4'd3,0,0,0,0), "baslat_release");
        step(1, 4'b0000, 0, 4'hA, e(0,0,0,4'h0,4'd0,0,0,0,0), "rst_mid_round");
        step(0, 4'b0000, 0, 4'hA, e(0,0,0,4'h0,4'd0,0,0,0,0), "idle_after_rst");

        // Round with target A: step wrap and mid-round sayi_giris change
        step(0, 4'b1000, 0, 4'hA, e(1,0,0,4'hA,4'd3,0,0,0,0), "start_A");
        step(0, 4'b0000, 0, 4'h3, e(1,0,0,4'hA,4'd3,0,0,0,0), "sayi_giris_ignored");
        for (int i = 1; i <= 5; i++) begin
            step(0, 4'b0100, 0, 4'h3, e(1,2'(i % 4),0,4'hA,4'd3,0,0,0,0), "sag_step");
            step(0, 4'b0000, 0, 4'h3, e(1,2'(i % 4),0,4'hA,4'd3,0,0,0,0), "sag_step_rel");
        end
        for (int j = 1; j <= 2; j++) begin
            step(0, 4'b0010, 0, 4'h3, e(1,1,2'(j),4'hA,4'd3,0,0,0,0), "asagi_step");
            step(0, 4'b0000, 0, 4'h3, e(1,1,2'(j),4'hA,4'd3,0,0,0,0), "asagi_step_rel");
        end
        step(0, 4'b0110, 0, 4'h3, e(1,2,3,4'hA,4'd3,0,0,0,0), "both_step");
        step(0, 4'b0000, 0, 4'h3, e(1,2,3,4'hA,4'd3,0,0,0,0), "both_rel");

        // Three misses -> loss; onay has priority over a simultaneous move
        step(0, 4'b0101, 0, 4'h3, e(2,2,3,4'hA,4'd3,1,0,0,0), "onay_priority");
        step(0, 4'b0000, 0, 4'h3, e(1,2,3,4'hA,4'd2,0,0,0,0), "miss1");
        step(0, 4'b0001, 0, 4'h3, e(2,2,3,4'hA,4'd2,1,0,0,0), "kontrol2");
        step(0, 4'b0000, 0, 4'h3, e(1,2,3,4'hA,4'd1,0,0,0,0), "miss2");
        step(0, 4'b0001, 0, 4'h3, e(2,2,3,4'hA,4'd1,1,0,0,0), "kontrol3");
        step(0, 4'b0000, 0, 4'h3, e(4,2,3,4'hA,4'd0,0,0,1,0), "lose");
        step(0, 4'b0100, 0, 4'h3, e(4,2,3,4'hA,4'd0,0,0,1,0), "lose_hold");
        step(0, 4'b0000, 0, 4'h3, e(4,2,3,4'hA,4'd0,0,0,1,0), "lose_hold_rel");

        // Restart from loss, win on second guess
        step(0, 4'b1000, 0, 4'h7, e(1,0,0,4'h7,4'd3,0,0,0,0), "restart_7");
        step(0, 4'b0000, 0, 4'h7, e(1,0,0,4'h7,4'd3,0,0,0,0), "restart_7_rel");
        step(0, 4'b0001, 0, 4'h7, e(2,0,0,4'h7,4'd3,1,0,0,0), "win_kontrol1");
        step(0, 4'b0000, 0, 4'h7, e(1,0,0,4'h7,4'd2,0,0,0,0), "win_miss1");
        step(0, 4'b0001, 0, 4'h7, e(2,0,0,4'h7,4'd2,1,0,0,0), "win_kontrol2");
        step(0, 4'b0000, 1, 4'h7, e(3,0,0,4'h7,4'd2,0,1,0,0), "win");
        step(0, 4'b0101, 1, 4'h7, e(3,0,0,4'h7,4'd2,0,1,0,0), "win_hold");
        step(0, 4'b0000, 0, 4'h7, e(3,0,0,4'h7,4'd2,0,1,0,0), "win_hold_rel");
        step(0, 4'b1000, 0, 4'h5, e(1,0,0,4'h5,4'd3,0,0,0,0), "restart_5");
        step(0, 4'b0000, 0, 4'h5, e(1,0,0,4'h5,4'd3,0,0,0,0), "restart_5_rel");

        // Reset during KONTROL
        step(0, 4'b0001, 0, 4'h5, e(2,0,0,4'h5,4'd3,1,0,0,0), "kontrol_before_rst");
        step(1, 4'b0000, 1, 4'h5, e(0,0,0,4'h0,4'd0,0,0,0,0), "rst_in_kontrol");
        step(0, 4'b0000, 0, 4'h5, e(0,0,0,4'h0,4'd0,0,0,0,0), "idle_after_rst2");
        step(0, 4'b1000, 0, 4'h5, e(1,0,0,4'h5,4'd3,0,0,0,0), "start_idle_round");

`ifdef TAHMIN_ZAMAN_ASIMI_EN
        for (int k = 1; k <= 9; k++)
            step(0, 4'b0000, 0, 4'h5, e(1,0,0,4'h5,4'd3,0,0,0,0), "idle_before_timeout");
        step(0, 4'b0000, 0, 4'h5, e(2,0,0,4'h5,4'd3,1,0,0,1), "timeout");
        step(0, 4'b0000, 0, 4'h5, e(1,0,0,4'h5,4'd2,0,0,0,0), "after_timeout");
        for (int k = 1; k <= 4; k++)
            step(0, 4'b0000, 0, 4'h5, e(1,0,0,4'h5,4'd2,0,0,0,0), "idle_before_sag");
        step(0, 4'b0100, 0, 4'h5, e(1,1,0,4'h5,4'd2,0,0,0,0), "sag_restarts_timer");
        for (int k = 1; k <= 9; k++)
            step(0, 4'b0000, 0, 4'h5, e(1,1,0,4'h5,4'd2,0,0,0,0), "idle_after_sag");
        step(0, 4'b0000, 0, 4'h5, e(2,1,0,4'h5,4'd2,1,0,0,1), "timeout_delayed");
`else
        for (int k = 1; k <= 20; k++)
            step(0, 4'b0000, 0, 4'h5, e(1,0,0,4'h5,4'd3,0,0,0,0), "no_timeout");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tahmin_kontrol.md
# tahmin_kontrol

Round sequencer for the number-guessing grid datapath. Turns player button presses into 2-bit right/down step registers, latches the target number at round start, and submits guesses to the combinational guess checker. It counts the remaining attempts and ends each round in a win or loss state.

## Interface
- MAX_DENEME, 3: attempts per round, legal 1..15
- ZAMAN_SINIRI, 1000: idle-cycle limit in SECIM, legal 2..65535, used only with the timeout feature
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- baslat  in  1  start/restart button, synchronized and debounced externally
- btn_sag  in  1  step-right button
- btn_asagi  in  1  step-down button
- btn_onay  in  1  confirm-guess button
- sayi_giris  in  4  target number from switches
- tahmin_dogru  in  1  checker result for current sag_adim/asagi_adim/sayi, combinational, same cycle
- sag_adim  out  2  right-step register to checker
- asagi_adim  out  2  down-step register to checker
- sayi  out  4  latched target to checker
- kalan_deneme  out  4  attempts remaining
- durum  out  3  state code
- kontrol_gecerli  out  1  high during the check cycle
- kazandi  out  1  high in KAZANDI
- kaybetti  out  1  high in KAYBETTI
- zaman_asimi  out  1  one-cycle timeout pulse, constant 0 when the feature is compiled out

## Operation
- Press detection: each button has a registered copy b_q. Press = b && !b_q. b_q is reset to 1, so a button held through reset gives no press until it is released.
- States and durum codes: BOSTA=0, SECIM=1, KONTROL=2, KAZANDI=3, KAYBETTI=4. Codes 5..7 are unreachable and go to BOSTA next cycle.
- BOSTA: baslat press -> SECIM. sayi<=sayi_giris, sag_adim<=0, asagi_adim<=0, kalan_deneme<=MAX_DENEME. Other buttons are ignored.
- SECIM:
  - btn_sag press: sag_adim+1 mod 4, so 3 wraps to 0.
  - btn_asagi press: asagi_adim+1 mod 4.
  - Both in the same cycle: both increment.
  - btn_onay press -> KONTROL. Any move press in that same cycle is dropped, so onay has priority.
  - baslat is ignored.
- KONTROL: exactly one cycle, kontrol_gecerli=1. tahmin_dogru is sampled at the end of the cycle.
  - tahmin_dogru=1 -> KAZANDI; kalan_deneme unchanged.
  - tahmin_dogru=0 and kalan_deneme=1 -> KAYBETTI, kalan_deneme<=0.
  - Otherwise kalan_deneme-1 -> SECIM; step registers are kept.
- KAZANDI / KAYBETTI: all outputs hold. baslat press starts a new round exactly as from BOSTA, relatching sayi_giris.
- sayi changes only on a round start. sayi_giris changes mid-round have no effect.

## Timing
- Reset values: state BOSTA, durum=0, sag_adim=0, asagi_adim=0, sayi=0, kalan_deneme=0. kontrol_gecerli, kazandi, kaybetti and zaman_asimi are all 0.
- Rst has priority over every press in the same cycle. Rst mid-round aborts to BOSTA with no result.
- Move press: step register updates on the same edge that samples the rising input; new value is visible the next cycle.
- Guess latency: onay sampled at edge N; KONTROL during cycle N..N+1; result state visible after edge N+1.
- One press per rising input edge. Holding a button never repeats.
- kazandi, kaybetti and kontrol_gecerli are decoded from registered state, with no combinational path from inputs.

## Configuration
- TAHMIN_ZAMAN_ASIMI_EN defined: a 16-bit idle counter runs in SECIM.
  - It clears on entry to SECIM and on any sag or asagi press.
  - When it reaches ZAMAN_SINIRI-1 with no onay press, the FSM enters KONTROL as if onay were pressed, and zaman_asimi pulses for one cycle on that transition.
- Not defined: no counter, zaman_asimi tied to 0, SECIM waits indefinitely.

## Test plan
- Reset with btn_sag held high, then release and press once: no step until release; after the press, sag_adim=1, durum=1 (round started via baslat first).
- Round start with sayi_giris=4'hA; press sag 5 times, asagi 2 times: sag_adim=1 (wrap), asagi_adim=2, sayi=A.
- MAX_DENEME=3, bench holds tahmin_dogru=0, onay three times: kalan_deneme 3->2->1->0, durum=4, kaybetti=1, kontrol_gecerli pulses exactly 3 cycles.
- tahmin_dogru=1 on the second onay: durum=3, kazandi=1, kalan_deneme=2. Then baslat with sayi_giris=4'h5: sayi=5, steps 0, kalan_deneme=3.
- onay and sag pressed in the same cycle with sag_adim=2: sag_adim stays 2, durum=2 next cycle. rst asserted in KONTROL: all outputs return to reset values next cycle.
- With TAHMIN_ZAMAN_ASIMI_EN and ZAMAN_SINIRI=10, no presses in SECIM: KONTROL entered 10 cycles after SECIM entry, zaman_asimi=1 for one cycle. A sag press at cycle 5 delays the timeout to 10 cycles after that press.
